fib_result_checker: RTL

Self-checking consumer for the ALU result stream driven by the Fibonacci control FSM. It sits on the datapath output, next to the ALU and flag register. It samples each result strobe and compares it against an internally generated Fibonacci reference. It reports the pass/fail verdict, error count and first-failure details, so benches and on-board LEDs read one verdict instead of a raw value trace.

---
 rtl/fib_result_checker_if.sv | 34 +++
 rtl/fib_result_checker.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fib_result_checker_if.sv
// Result-stream bus between the ALU datapath and the Fibonacci result checker.
`default_nettype none

interface fib_result_checker_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             result_valid;
  logic [WIDTH-1:0] result;
  logic [4:0]       flags;
  logic             busy;
  logic             done;
  logic             pass;
  logic [7:0]       err_count;
  logic [7:0]       term_idx;
  logic [WIDTH-1:0] expected;
  logic [7:0]       first_bad_idx;
  logic [WIDTH-1:0] first_bad_value;
  logic [4:0]       first_bad_flags;

  modport master (
    output start, result_valid, result, flags,
    input  busy, done, pass, err_count, term_idx, expected,
           first_bad_idx, first_bad_value, first_bad_flags
  );

  modport slave (
    input  start, result_valid, result, flags,
    output busy, done, pass, err_count, term_idx, expected,
           first_bad_idx, first_bad_value, first_bad_flags
  );
endinterface

`default_nettype wire

// File: rtl/fib_result_checker.sv
// Checks a stream of ALU results against an internal Fibonacci reference and
// reports a per-run verdict, saturating error count and first-failure details.
`default_nettype none

module fib_result_checker #(
  parameter int               WIDTH     = 16,
  parameter int               NUM_TERMS = 16,
  parameter logic [WIDTH-1:0] SEED_A    = '0,
  parameter logic [WIDTH-1:0] SEED_B    = WIDTH'(1)
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  fib_result_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'(NUM_TERMS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [7:0]       err_q, err_d;
  logic [7:0]       idx_q, idx_d;
  logic             pass_q, pass_d;
  logic             done_q, done_d;
  logic [7:0]       fb_idx_q, fb_idx_d;
  logic [WIDTH-1:0] fb_val_q, fb_val_d;
  logic [4:0]       fb_flags_q, fb_flags_d;

  logic [WIDTH-1:0] expected_w;
  logic             mismatch_w;

  assign expected_w = ra_q + rb_q;
  assign mismatch_w = (bus.result != expected_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ra_q       <= SEED_A;
      rb_q       <= SEED_B;
      err_q      <= '0;
      idx_q      <= '0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
      fb_idx_q   <= '0;
      fb_val_q   <= '0;
      fb_flags_q <= '0;
    end else begin
      state_q    <= state_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      done_q     <= done_d;
      fb_idx_q   <= fb_idx_d;
      fb_val_q   <= fb_val_d;
      fb_flags_q <= fb_flags_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    err_d      = err_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    done_d     = 1'b0;
    fb_idx_d   = fb_idx_q;
    fb_val_d   = fb_val_q;
    fb_flags_d = fb_flags_q;

    // start overrides everything, including a result strobe in the same cycle
    if (bus.start) begin
      state_d    = S_RUN;
      ra_d       = SEED_A;
      rb_d       = SEED_B;
      err_d      = '0;
      idx_d      = '0;
      pass_d     = 1'b0;
      fb_idx_d   = '0;
      fb_val_d   = '0;
      fb_flags_d = '0;
    end else if (state_q == S_RUN && bus.result_valid) begin
      // Reference advances from itself so a bad result never cascades
      ra_d  = rb_q;
      rb_d  = expected_w;
      idx_d = idx_q + 8'd1;
      if (mismatch_w) begin
        if (err_q != 8'hFF) begin
          err_d = err_q + 8'd1;
        end
        if (err_q == 8'd0) begin
          fb_idx_d   = idx_q;
          fb_val_d   = bus.result;
          fb_flags_d = bus.flags;
        end
      end
      if (idx_q == LAST_IDX) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        pass_d  = (err_q == 8'd0) && !mismatch_w;
      end
    end
  end

  assign bus.busy            = (state_q == S_RUN);
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.term_idx        = idx_q;
  assign bus.expected        = expected_w;
  assign bus.first_bad_idx   = fb_idx_q;
  assign bus.first_bad_value = fb_val_q;
  assign bus.first_bad_flags = fb_flags_q;

endmodule

`default_nettype wire
